// File: rtl/uart_report_pkg.sv
// uart_report_pkg: shared FSM state type and message constants for the count reporter
package uart_report_pkg;

    typedef enum logic [1:0] {IDLE, CONVERT, SEND} state_t;

    localparam int MSG_LEN = 11;
    localparam logic [31:0] PREFIX = "BTN:";
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

endpackage

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serialiser, LSB first; ready rises in the last stop-bit cycle so frames chain with no gap
module uart_tx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       start,
    output logic       tx,
    output logic       ready
);

    localparam int BW = $clog2(CLKS_PER_BIT + 1);

    logic          active;
    logic [8:0]    shreg;
    logic [3:0]    bit_cnt;
    logic [BW-1:0] baud;
    logic          bit_end;

    assign bit_end = baud == BW'(CLKS_PER_BIT - 1);
    assign ready   = !active || (bit_end && bit_cnt == 4'd9);

    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= 1'b0;
            tx      <= 1'b1;
            shreg   <= '0;
            bit_cnt <= '0;
            baud    <= '0;
        end else if (start && ready) begin
            active  <= 1'b1;
            tx      <= 1'b0;
            shreg   <= {1'b1, data};
            bit_cnt <= '0;
            baud    <= '0;
        end else if (active) begin
            baud <= bit_end ? '0 : baud + 1'b1;
            if (bit_end && bit_cnt == 4'd9) begin
                active <= 1'b0;
                tx     <= 1'b1;
            end else if (bit_end) begin
                tx      <= shreg[0];
                shreg   <= {1'b1, shreg[8:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/uart_count_reporter.sv
// uart_count_reporter: converts each sampled count to "BTN:ddddd\r\n" and streams it over a UART
module uart_count_reporter
    import uart_report_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int DIGITS       = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        event_valid,
    input  logic [15:0] count,
    output logic        tx,
    output logic        busy,
    output logic        overrun
);

    localparam int NB = MSG_LEN - 5 + DIGITS;
    localparam int BW = 4 * DIGITS;

    state_t        state, state_n;
    logic [15:0]   bin, pend;
    logic          pend_valid;
    logic [BW-1:0] bcd, bcd_adj;
    logic [3:0]    iter, byte_idx;
    logic [7:0]    data;
    logic          start, ready, done, load;

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk  (clk),
        .rst  (rst),
        .data (data),
        .start(start),
        .tx   (tx),
        .ready(ready)
    );

    assign done = state == SEND && byte_idx == 4'(NB) && ready;
    assign load = state == IDLE && event_valid;

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end

    always_comb begin
        state_n = state == IDLE    ? (event_valid ? CONVERT : IDLE) :
                  state == CONVERT ? (iter == 4'd15 ? SEND : CONVERT) :
                  state == SEND    ? (done ? ((pend_valid || event_valid) ? CONVERT : IDLE) : SEND) :
                  IDLE;
    end

    always_comb begin
        start = state == SEND && byte_idx != 4'(NB) && ready;
        busy  = state != IDLE || pend_valid;
    end

    // Digits ride in the BCD register MSD-first; everything else is a fixed byte
    always_comb begin
        data = byte_idx < 4'd4 ? PREFIX[8*(3 - byte_idx[1:0]) +: 8] :
               byte_idx == 4'(NB - 2) ? CR : LF;
        for (int d = 0; d < DIGITS; d++)
            if (byte_idx == 4'(4 + d)) data = {4'h3, bcd[4*(DIGITS-1-d) +: 4]};
    end

    always_comb begin
        bcd_adj = bcd;
        for (int d = 0; d < DIGITS; d++)
            bcd_adj[4*d +: 4] = bcd[4*d +: 4] >= 4'd5 ? bcd[4*d +: 4] + 4'd3 : bcd[4*d +: 4];
    end

    // On completion a stored value wins; a same-cycle event then takes the freed slot
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend       <= '0;
            overrun    <= 1'b0;
            iter       <= '0;
            byte_idx   <= '0;
            bin        <= '0;
            bcd        <= '0;
        end else begin
            overrun <= 1'b0;
            if (load || done) begin
                bin        <= (done && pend_valid) ? pend : count;
                bcd        <= '0;
                iter       <= '0;
                byte_idx   <= '0;
                pend_valid <= done && pend_valid && event_valid;
                if (event_valid) pend <= count;
            end else begin
                if (event_valid && state != IDLE) begin
                    pend       <= count;
                    pend_valid <= 1'b1;
                    overrun    <= pend_valid;
                end
                if (state == CONVERT) begin
                    {bcd, bin} <= {bcd_adj[BW-2:0], bin, 1'b0};
                    iter       <= iter + 4'd1;
                end
                if (start) byte_idx <= byte_idx + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_count_reporter.sv
// tb_uart_count_reporter: directed and random events against a timeline model of messages and a UART decoder
module tb_uart_count_reporter;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;
    localparam int MSG   = 11;
    localparam int LAT   = 17;

    typedef struct {
        logic [7:0] b;
        int         t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        event_valid = 1'b0;
    logic [15:0] count = '0;
    logic        tx, busy, overrun;

    int checks = 0;
    int errors = 0;

    uart_count_reporter #(.CLKS_PER_BIT(CPB), .DIGITS(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .event_valid(event_valid),
        .count      (count),
        .tx         (tx),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    int   cyc = 0;
    exp_t exp_q[$];
    bit   m_active = 0, m_pend_v = 0, m_ovr = 0;
    int   m_pend, m_done;

    function automatic void push_msg(input int v);
        logic [7:0] msg [MSG];
        logic [31:0] pre = "BTN:";
        for (int k = 0; k < 4; k++) msg[k] = pre[8*(3-k) +: 8];
        msg[4] = 8'h30 + 8'(v / 10000 % 10);
        msg[5] = 8'h30 + 8'(v / 1000 % 10);
        msg[6] = 8'h30 + 8'(v / 100 % 10);
        msg[7] = 8'h30 + 8'(v / 10 % 10);
        msg[8] = 8'h30 + 8'(v % 10);
        msg[9] = 8'h0D;
        msg[10] = 8'h0A;
        for (int k = 0; k < MSG; k++) exp_q.push_back('{msg[k], cyc + LAT + FRAME * k});
        m_active = 1;
        m_done = cyc + LAT + MSG * FRAME;
    endfunction

    // Message-level timeline: one message in flight, one waiting value, completion at a known edge
    always @(posedge clk) begin
        cyc++;
        m_ovr = 0;
        if (rst) begin
            m_active = 0;
            m_pend_v = 0;
            exp_q.delete();
        end else if (!m_active) begin
            if (event_valid) push_msg(int'(count));
        end else if (cyc == m_done) begin
            if (m_pend_v) begin
                push_msg(m_pend);
                m_pend_v = event_valid;
                m_pend = int'(count);
            end else if (event_valid) push_msg(int'(count));
            else m_active = 0;
        end else if (event_valid) begin
            m_ovr = m_pend_v;
            m_pend = int'(count);
            m_pend_v = 1;
        end
    end

    bit          rx_on = 0;
    int          rx_n, rx_t0, rx_bytes = 0, ovr_seen = 0;
    logic [39:0] fb;

    always @(negedge clk) begin
        if (cyc >= 2) begin
            check("busy", 32'(busy), 32'(m_active || m_pend_v));
            check("overrun", 32'(overrun), 32'(m_ovr));
            ovr_seen += int'(overrun);
        end
        if (rst) rx_on = 0;
        else if (!rx_on) begin
            if (tx === 1'b0) begin
                rx_on = 1;
                rx_n = 1;
                fb[0] = 1'b0;
                rx_t0 = cyc;
            end
        end else begin
            fb[rx_n] = tx;
            rx_n++;
            if (rx_n == FRAME) begin
                int bad = 0;
                logic [7:0] got;
                exp_t e;
                for (int g = 0; g < 10; g++)
                    for (int s = 1; s < CPB; s++) if (fb[CPB*g+s] !== fb[CPB*g]) bad++;
                if (fb[9*CPB] !== 1'b1) bad++;
                for (int i = 0; i < 8; i++) got[i] = fb[CPB*(i+1)];
                check("framing", 32'(bad), 0);
                if (exp_q.size() == 0) check("extra_byte", {24'h0, got}, 32'h100);
                else begin
                    e = exp_q.pop_front();
                    check("byte", {24'h0, got}, {24'h0, e.b});
                    check("start_cycle", 32'(rx_t0), 32'(e.t));
                end
                rx_bytes++;
                rx_on = 0;
            end
        end
    end

    task automatic pulse(input logic [15:0] v);
        @(negedge clk);
        event_valid = 1'b1;
        count = v;
        @(negedge clk);
        event_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            ok = !m_active && !m_pend_v && exp_q.size() == 0 && !rx_on;
        end
        check("idle_timeout", 32'(ok), 1);
    endtask

    int base;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_tx", 32'(tx), 1);
        check("reset_busy", 32'(busy), 0);
        check("reset_overrun", 32'(overrun), 0);

        base = ovr_seen;
        pulse(16'd42);
        wait_idle();
        check("ovr_42", 32'(ovr_seen - base), 0);

        pulse(16'd65535);
        wait_idle();
        repeat (20) @(negedge clk);
        pulse(16'd0);
        wait_idle();

        base = ovr_seen;
        pulse(16'd1);
        repeat (60) @(negedge clk);
        pulse(16'd2);
        repeat (60) @(negedge clk);
        pulse(16'd3);
        wait_idle();
        check("ovr_123", 32'(ovr_seen - base), 1);

        base = rx_bytes;
        pulse(16'd123);
        for (int i = 0; i < 400 && rx_bytes < base + 5; i++) @(negedge clk);
        check("reach_byte5", 32'(rx_bytes - base), 5);
        repeat (CPB * 4) @(negedge clk);
        rst = 1'b1;
        event_valid = 1'b1;
        count = 16'd5;
        @(negedge clk);
        rst = 1'b0;
        event_valid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            check("tx_after_rst", 32'(tx), 1);
            @(negedge clk);
        end
        pulse(16'd7);
        wait_idle();

        base = ovr_seen;
        @(negedge clk);
        event_valid = 1'b1;
        count = 16'd9;
        @(negedge clk);
        count = 16'd10;
        @(negedge clk);
        count = 16'd11;
        @(negedge clk);
        event_valid = 1'b0;
        wait_idle();
        check("ovr_held", 32'(ovr_seen - base), 1);

        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(0, 600)) @(negedge clk);
            pulse(16'($urandom));
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
